spu_map_algebra_lane: RTL and testbench
=======================================

// Module: spu_map_algebra_lane
// PURPOSE
//  Parametrised successor to the Mini SPU datapath: streaming local/zonal map-algebra lane for raster cells.
//  Accepts operand pairs (A,B) from the tt_um_spatial_processing_unit input-unpacking logic over valid/ready.
//  Applies the configured op, honouring a NODATA sentinel, and buffers results in an output FIFO toward the pin mux.
//  Adds runtime op select, NODATA masking, zonal accumulation and backpressure, none of which the fixed SPU datapath has.
// PARAMETERS
//  DATA_W      8  cell width in bits (A, B, result)
//  ACC_W      16  zonal accumulator width; must be > DATA_W
//  FIFO_DEPTH  4  result FIFO entries; power of two, >= 2
// PORTS
//  clk         in   1       single clock, rising edge
//  rst_n       in   1       synchronous, active-low reset
//  cfg_we      in   1       config write strobe
//  cfg_op      in   3       op code, spu_pkg::op_e
//  cfg_nd_en   in   1       NODATA masking enable
//  cfg_nd      in   DATA_W  NODATA sentinel value
//  cfg_err     out  1       1-cycle pulse: cfg write rejected
//  in_valid    in   1       operand beat valid
//  in_ready    out  1       lane can accept a beat
//  in_a        in   DATA_W  operand A
//  in_b        in   DATA_W  operand B
//  in_last     in   1       last cell of row/zone
//  out_valid   out  1       FIFO head valid
//  out_ready   in   1       consumer accepts head
//  out_data    out  DATA_W  result
//  out_last    out  1       result closes a row/zone
//  busy        out  1       FIFO non-empty or zonal run open
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): op=PASS, nd_en=0, nd=0, FIFO emptied, accumulator cleared; all outputs 0 except in_ready=1.
//  Reset mid-run discards FIFO contents and the partial zonal sum; no partial output.
//  Handshake: beat accepted when in_valid&in_ready; popped when out_valid&out_ready. Data held while valid&!ready.
//  in_ready = (count < FIFO_DEPTH); it does NOT see same-cycle pop (full+pop -> stall one cycle).
//  Latency: beat accepted at edge N -> out_valid=1 after edge N (1 cycle) when FIFO was empty; order strictly FIFO.
//  Ops (results are DATA_W, unsigned, saturating):
//   0 PASS A; 1 ADD min(A+B,max); 2 SUB max(A-B,0); 3 MIN; 4 MAX; 5 AVG floor((A+B)/2), DATA_W+1-bit sum;
//   6 THRESH (A>=B)?1:0; 7 ZSUM accumulate A until in_last.
//  NODATA (nd_en=1): ops 1-6 -> result=nd if A==nd or B==nd; PASS checks A only.
//  Ops 0-6: one result per beat, out_last=in_last.
//  ZSUM: NODATA beats skipped; in_last beat adds then pushes min(acc,2^DATA_W-1), out_last=1, acc cleared.
//   All beats of a zone NODATA -> pushes nd. Beats without in_last push nothing (in_ready still honoured).
//  Config: applied at edge when cfg_we=1 and busy=0; when busy=1 ignored and cfg_err=1 next cycle.
//   cfg_we and an accepted beat in the same cycle: beat uses old cfg, write rejected (busy set).
//  Counter/pointer wrap: FIFO pointers log2(FIFO_DEPTH) bits, count log2+1 bits; no overflow possible by design.
// STRUCTURE
//  spu_pkg: op_e enum (OP_PASS..OP_ZSUM), OP_W=3, default DATA_W/ACC_W.
//  Sub-module spu_result_fifo (WIDTH=DATA_W+1, DEPTH) holding {last,data}; lane = cfg regs + ALU + acc + FIFO.
//  ALU combinational; single register stage is the FIFO write.
// TESTING
//  Reset: hold rst_n=0 2 cycles -> out_valid=0, in_ready=1, busy=0, cfg_err=0; PASS A=0x5A -> 0x5A next cycle.
//  Arithmetic: ADD 200+100 -> 255; SUB 50-80 -> 0; AVG 7,8 -> 7; THRESH 9>=9 -> 1; MIN 3,4 -> 3.
//  NODATA: nd=0xFF,nd_en=1, MAX A=0xFF,B=3 -> 0xFF; nd_en=0 same -> 0xFF; MIN A=0xFF,B=3 en=1 -> 0xFF, en=0 -> 3.
//  ZSUM: 10,20,30(last) -> one output 60,out_last=1; 200,100(last) -> 255; nd,nd(last) -> nd.
//  Backpressure: out_ready=0, drive 5 beats, DEPTH=4 -> in_ready=0 after 4th; release -> 4 results in order, then 5th.
//  Config/reset: cfg_we while busy -> cfg_err pulse, op unchanged; rst_n=0 mid-ZSUM -> no output, next zone sums from 0.

Source files
------------

// File: rtl/spu_pkg.sv
// Shared types and defaults for the SPU map-algebra lane.
package spu_pkg;

    localparam int OP_W          = 3;
    localparam int DATA_W_DEFAULT = 8;
    localparam int ACC_W_DEFAULT  = 16;

    typedef enum logic [OP_W-1:0] {
        OP_PASS   = 3'd0,
        OP_ADD    = 3'd1,
        OP_SUB    = 3'd2,
        OP_MIN    = 3'd3,
        OP_MAX    = 3'd4,
        OP_AVG    = 3'd5,
        OP_THRESH = 3'd6,
        OP_ZSUM   = 3'd7
    } op_e;

endpackage

// File: rtl/spu_result_fifo.sv
// Result FIFO holding {last,data}; head is presented combinationally from storage.
module spu_result_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             valid,
    output logic             ready,
    output logic [WIDTH-1:0] rd_data
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign valid     = (count_r != {(PTR_W+1){1'b0}});
    assign ready     = (count_r < (PTR_W+1)'(DEPTH));
    assign push_ok_s = push & ready;
    assign pop_ok_s  = pop & valid;
    assign rd_data   = valid ? mem_r[rd_ptr_r] : {WIDTH{1'b0}};

    // Storage write; contents are don't-care until counted valid.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (PTR_W+1)'(1);
                2'b01:   count_r <= count_r - (PTR_W+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/spu_map_algebra_lane.sv
// Streaming map-algebra lane: config registers, NODATA-aware ALU, zonal accumulator
// and a result FIFO toward the pin mux.
module spu_map_algebra_lane
    import spu_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEFAULT,
    parameter int ACC_W      = ACC_W_DEFAULT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [OP_W-1:0]   cfg_op,
    input  logic              cfg_nd_en,
    input  logic [DATA_W-1:0] cfg_nd,
    output logic              cfg_err,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy
);
    localparam logic [ACC_W-1:0] DATA_MAX = {{(ACC_W-DATA_W){1'b0}}, {DATA_W{1'b1}}};

    op_e               op_r;
    logic              nd_en_r;
    logic [DATA_W-1:0] nd_r;
    logic [ACC_W-1:0]  acc_r;
    logic              zone_any_r;
    logic              zone_open_r;
    logic              cfg_err_r;

    logic              accept_s;
    logic              cfg_ok_s;
    logic              a_nd_s;
    logic              b_nd_s;
    logic [DATA_W:0]   sum_s;
    logic [ACC_W:0]    acc_sum_s;
    logic [ACC_W-1:0]  acc_next_s;
    logic              zone_any_next_s;
    logic [DATA_W-1:0] result_s;
    logic              push_s;
    logic              fifo_valid_s;
    logic [DATA_W:0]   fifo_head_s;

    assign accept_s = in_valid & in_ready;
    assign busy     = fifo_valid_s | zone_open_r;
    // A beat accepted alongside a config write keeps the old config, so the write must lose.
    assign cfg_ok_s = cfg_we & ~busy & ~accept_s;
    assign a_nd_s   = nd_en_r & (in_a == nd_r);
    assign b_nd_s   = nd_en_r & (in_b == nd_r);
    assign sum_s    = {1'b0, in_a} + {1'b0, in_b};
    assign acc_sum_s = {1'b0, acc_r} +
                       (a_nd_s ? {(ACC_W+1){1'b0}} : {{(ACC_W+1-DATA_W){1'b0}}, in_a});
    assign acc_next_s      = acc_sum_s[ACC_W] ? {ACC_W{1'b1}} : acc_sum_s[ACC_W-1:0];
    assign zone_any_next_s = zone_any_r | ~a_nd_s;
    assign push_s   = accept_s & ((op_r != OP_ZSUM) | in_last);

    // Result selection with NODATA override.
    always_comb begin
        result_s = in_a;
        case (op_r)
            OP_PASS:   result_s = in_a;
            OP_ADD:    result_s = sum_s[DATA_W] ? {DATA_W{1'b1}} : sum_s[DATA_W-1:0];
            OP_SUB:    result_s = (in_a >= in_b) ? (in_a - in_b) : {DATA_W{1'b0}};
            OP_MIN:    result_s = (in_a < in_b) ? in_a : in_b;
            OP_MAX:    result_s = (in_a > in_b) ? in_a : in_b;
            OP_AVG:    result_s = sum_s[DATA_W:1];
            OP_THRESH: result_s = {{(DATA_W-1){1'b0}}, (in_a >= in_b)};
            OP_ZSUM:   result_s = (acc_next_s > DATA_MAX) ? {DATA_W{1'b1}}
                                                          : acc_next_s[DATA_W-1:0];
            default:   result_s = in_a;
        endcase
        if (op_r == OP_ZSUM) begin
            if (!zone_any_next_s) begin
                result_s = nd_r;
            end else begin
                result_s = result_s;
            end
        end else if (a_nd_s || (b_nd_s && (op_r != OP_PASS))) begin
            result_s = nd_r;
        end else begin
            result_s = result_s;
        end
    end

    // Config registers, reject pulse and zonal accumulator state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_r        <= OP_PASS;
            nd_en_r     <= 1'b0;
            nd_r        <= {DATA_W{1'b0}};
            acc_r       <= {ACC_W{1'b0}};
            zone_any_r  <= 1'b0;
            zone_open_r <= 1'b0;
            cfg_err_r   <= 1'b0;
        end else begin
            cfg_err_r <= cfg_we & ~cfg_ok_s;
            if (cfg_ok_s) begin
                op_r    <= op_e'(cfg_op);
                nd_en_r <= cfg_nd_en;
                nd_r    <= cfg_nd;
            end
            if (accept_s && (op_r == OP_ZSUM)) begin
                if (in_last) begin
                    acc_r       <= {ACC_W{1'b0}};
                    zone_any_r  <= 1'b0;
                    zone_open_r <= 1'b0;
                end else begin
                    acc_r       <= acc_next_s;
                    zone_any_r  <= zone_any_next_s;
                    zone_open_r <= 1'b1;
                end
            end
        end
    end

    assign cfg_err   = cfg_err_r;
    assign out_valid = fifo_valid_s;
    assign out_last  = fifo_head_s[DATA_W];
    assign out_data  = fifo_head_s[DATA_W-1:0];

    spu_result_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data ({in_last, result_s}),
        .pop       (out_ready),
        .valid     (fifo_valid_s),
        .ready     (in_ready),
        .rd_data   (fifo_head_s)
    );

endmodule

// File: tb/tb_spu_map_algebra_lane.sv
// Directed and randomized checks of spu_map_algebra_lane against a queue-based reference model.
module tb_spu_map_algebra_lane;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_we = 1'b0;
    logic [2:0] cfg_op = 3'd0;
    logic       cfg_nd_en = 1'b0;
    logic [7:0] cfg_nd = 8'd0;
    logic       cfg_err;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_a = 8'd0;
    logic [7:0] in_b = 8'd0;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;

    int errors = 0;
    int checks = 0;

    // reference model state
    int         m_op = 0;
    bit         m_nd_en = 1'b0;
    int         m_nd = 0;
    int         m_acc = 0;
    bit         m_any = 1'b0;
    bit         m_open = 1'b0;
    logic [8:0] q[$];

    spu_map_algebra_lane #(.DATA_W(8), .ACC_W(16), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_op(cfg_op),
        .cfg_nd_en(cfg_nd_en), .cfg_nd(cfg_nd), .cfg_err(cfg_err),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic bit m_busy();
        return (q.size() != 0) || m_open;
    endfunction

    function automatic int ref_op(int op, int a, int b, bit en, int nd);
        int r;
        case (op)
            0: r = a;
            1: r = (a + b > 255) ? 255 : a + b;
            2: r = (a > b) ? a - b : 0;
            3: r = (a < b) ? a : b;
            4: r = (a > b) ? a : b;
            5: r = (a + b) / 2;
            6: r = (a >= b) ? 1 : 0;
            default: r = a;
        endcase
        if (en && (a == nd || (op != 0 && b == nd))) r = nd;
        return r;
    endfunction

    task automatic model_beat();
        int a = int'(in_a);
        if (m_op == 7) begin
            if (!(m_nd_en && a == m_nd)) begin
                m_acc += a;
                m_any = 1'b1;
            end
            if (in_last) begin
                q.push_back({1'b1, m_any ? ((m_acc > 255) ? 8'd255 : 8'(m_acc)) : 8'(m_nd)});
                m_acc = 0; m_any = 1'b0; m_open = 1'b0;
            end else begin
                m_open = 1'b1;
            end
        end else begin
            q.push_back({in_last, 8'(ref_op(m_op, a, int'(in_b), m_nd_en, m_nd))});
        end
    endtask

    // One clock: update the model from pre-edge inputs, then check post-edge outputs.
    task automatic step();
        bit         acc;
        bit         err_n = 1'b0;
        bit         was_busy;
        logic [8:0] e;
        if (!rst_n) begin
            m_op = 0; m_nd_en = 1'b0; m_nd = 0; m_acc = 0; m_any = 1'b0; m_open = 1'b0;
            q.delete();
        end else begin
            was_busy = m_busy();
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("unexpected_pop", 32'd1, 32'd0);
                else begin
                    e = q.pop_front();
                    chk("out_data", out_data, e[7:0]);
                    chk("out_last", out_last, e[8]);
                end
            end
            if (cfg_we && (was_busy || acc)) err_n = 1'b1;
            if (acc) model_beat();
            if (cfg_we && !err_n) begin
                m_op = int'(cfg_op); m_nd_en = cfg_nd_en; m_nd = int'(cfg_nd);
            end
        end
        @(posedge clk); #1;
        chk("cfg_err", cfg_err, err_n);
        chk("in_ready", in_ready, q.size() < 4);
        chk("out_valid", out_valid, q.size() != 0);
        chk("busy", busy, m_busy());
    endtask

    task automatic cfg(input int op, input bit en, input int nd);
        cfg_we = 1'b1; cfg_op = 3'(op); cfg_nd_en = en; cfg_nd = 8'(nd);
        step();
        cfg_we = 1'b0;
    endtask

    task automatic beat(input int a, input int b, input bit last);
        bit ok = 1'b0;
        in_valid = 1'b1; in_a = 8'(a); in_b = 8'(b); in_last = last;
        for (int i = 0; i < 20 && !ok; i++) begin
            ok = in_ready;
            step();
            if (!ok) out_ready = 1'b1;
        end
        if (!ok) chk("beat_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 50 && m_busy(); i++) step();
        chk("drain_empty", out_valid, 1'b0);
    endtask

    task automatic one(input int a, input int b, input int expv, input string tag);
        out_ready = 1'b0;
        beat(a, b, 1'b1);
        chk(tag, out_data, expv);
        drain();
    endtask

    initial begin
        int n, op, nd, a, b;
        bit en, last;

        // reset
        rst_n = 1'b0;
        step(); step();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cfg_err", cfg_err, 1'b0);
        chk("rst_out_data", out_data, 8'h00);
        rst_n = 1'b1;
        step();
        out_ready = 1'b0;
        beat(8'h5A, 0, 1'b0);
        chk("pass_latency_valid", out_valid, 1'b1);
        chk("pass_5a", out_data, 8'h5A);
        drain();

        // arithmetic
        cfg(1, 1'b0, 0);  one(200, 100, 255, "add_sat");
        cfg(2, 1'b0, 0);  one(50, 80, 0, "sub_floor");
        cfg(5, 1'b0, 0);  one(7, 8, 7, "avg");
        cfg(6, 1'b0, 0);  one(9, 9, 1, "thresh_eq");
        cfg(3, 1'b0, 0);  one(3, 4, 3, "min");

        // NODATA
        cfg(4, 1'b1, 8'hFF); one(8'hFF, 3, 8'hFF, "max_nd_en");
        cfg(4, 1'b0, 8'hFF); one(8'hFF, 3, 8'hFF, "max_nd_dis");
        cfg(3, 1'b1, 8'hFF); one(8'hFF, 3, 8'hFF, "min_nd_en");
        cfg(3, 1'b0, 8'hFF); one(8'hFF, 3, 3, "min_nd_dis");

        // zonal sum
        cfg(7, 1'b0, 0);
        out_ready = 1'b0;
        beat(10, 0, 1'b0);
        chk("zsum_no_out", out_valid, 1'b0);
        chk("zsum_busy", busy, 1'b1);
        beat(20, 0, 1'b0);
        beat(30, 0, 1'b1);
        chk("zsum_60", out_data, 60);
        chk("zsum_last", out_last, 1'b1);
        drain();
        out_ready = 1'b0;
        beat(200, 0, 1'b0);
        beat(100, 0, 1'b1);
        chk("zsum_sat", out_data, 255);
        drain();
        cfg(7, 1'b1, 8'hFF);
        out_ready = 1'b0;
        beat(8'hFF, 0, 1'b0);
        beat(8'hFF, 0, 1'b1);
        chk("zsum_all_nd", out_data, 8'hFF);
        drain();

        // backpressure
        cfg(0, 1'b0, 0);
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) beat(i, 0, 1'b0);
        chk("full_in_ready", in_ready, 1'b0);
        in_valid = 1'b1; in_a = 8'd5; in_last = 1'b1;
        step();
        chk("full_stall", in_ready, 1'b0);
        out_ready = 1'b1;
        beat(5, 0, 1'b1);
        drain();

        // config while busy
        out_ready = 1'b0;
        beat(8'h11, 8'h22, 1'b1);
        cfg(1, 1'b0, 0);
        chk("cfg_reject_pulse", cfg_err, 1'b1);
        step();
        drain();
        one(8'h11, 8'h22, 8'h11, "cfg_op_unchanged");

        // reset mid-zone
        cfg(7, 1'b0, 0);
        beat(10, 0, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midrst_no_out", out_valid, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        cfg(7, 1'b0, 0);
        out_ready = 1'b0;
        beat(5, 0, 1'b0);
        beat(6, 0, 1'b1);
        chk("midrst_fresh_sum", out_data, 11);
        drain();

        // randomized segments
        for (int s = 0; s < 40; s++) begin
            op = $urandom_range(0, 7);
            en = 1'($urandom_range(0, 1));
            nd = $urandom_range(0, 255);
            cfg(op, en, nd);
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                a = ($urandom_range(0, 3) == 0) ? nd : $urandom_range(0, 255);
                b = ($urandom_range(0, 3) == 0) ? nd : $urandom_range(0, 255);
                last = (i == n - 1) ? 1'b1 : ((op != 7) ? 1'($urandom_range(0, 1)) : 1'b0);
                out_ready = 1'($urandom_range(0, 1));
                beat(a, b, last);
            end
            drain();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
